// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader_pkg
//  Purpose  : Shared widths and loader state encoding.
//  Revision : 1.0
// ============================================================================
package prog_loader_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_SUM  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Receives a LEN/data/SUM framed byte stream and writes it to RAM.
//  Revision : 1.0
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    output logic              busy,
    output logic              run,
    output logic              done,
    output logic              err
);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_len;
    logic [ADDR_W-1:0]   r_idx;
    logic [DATA_W-1:0]   r_acc;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic                r_ram_wren;
    logic                r_run;
    logic                r_done;
    logic                r_err;
    logic                r_busy;
    logic                w_ready;
    logic                w_accept;
    logic                w_last;
    logic                w_sum_ok;

    assign w_accept = in_valid & w_ready;
    // len of 0 wraps to 255 here, giving a 256-byte frame
    assign w_last   = (r_idx == (r_len - 8'd1));
    assign w_sum_ok = (in_data == r_acc);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_LEN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = S_LEN;
        end else begin
            case (r_state)
                S_LEN:   if (w_accept) w_next_state = S_DATA;
                S_DATA:  if (w_accept && w_last) w_next_state = S_SUM;
                S_SUM:   if (w_accept) w_next_state = w_sum_ok ? S_DONE : S_ERR;
                S_DONE:  w_next_state = S_DONE;
                S_ERR:   w_next_state = S_ERR;
                default: w_next_state = S_LEN;
            endcase
        end
    end

    // Output logic: only the handshake is combinational
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_LEN, S_DATA, S_SUM: w_ready = ~clear;
            default:              w_ready = 1'b0;
        endcase
    end

    // Datapath: counter, accumulator, RAM port and status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_len       <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_wren  <= 1'b0;
            r_run       <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_ram_wren <= 1'b0;
            r_run      <= 1'b0;
            r_done     <= (w_next_state == S_DONE);
            r_err      <= (w_next_state == S_ERR);
            r_busy     <= (w_next_state != S_DONE);
            if (clear) begin
                r_idx <= '0;
                r_acc <= '0;
            end else if (w_accept) begin
                case (r_state)
                    S_LEN: begin
                        r_len <= in_data;
                        r_idx <= '0;
                        r_acc <= '0;
                    end
                    S_DATA: begin
                        r_ram_wren  <= 1'b1;
                        r_ram_addr  <= r_idx;
                        r_ram_wdata <= in_data;
                        r_acc       <= r_acc + in_data;
                        if (!w_last) begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                    S_SUM:   r_run <= w_sum_ok;
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = w_ready;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_wren  = r_ram_wren;
    assign run       = r_run;
    assign done      = r_done;
    assign err       = r_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire
